// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared types and constants for the FFT frame feeder.
//            - state_t : feeder FSM states
//            - DATA_W  : default complex sample width {imag, real}
//            - REAL_*/IMAG_* : single-precision float field positions
//            - CFG_FWD_INV_BIT : forward(1)/inverse(0) bit in the config word
// Revision : 1.0  initial release
// ============================================================================
package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int DATA_W   = 64;
  localparam int REAL_MSB = 31;
  localparam int REAL_LSB = 0;
  localparam int IMAG_MSB = 63;
  localparam int IMAG_LSB = 32;

  localparam int CFG_FWD_INV_BIT = 0;

  // True when a config word selects a forward transform.
  function automatic logic cfg_is_forward(input logic [7:0] cfg);
    return cfg[CFG_FWD_INV_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : axis_out_reg
// Purpose  : One-entry AXI-Stream output register. A load captures data and
//            last and raises valid; valid drops on an output handshake with
//            no new load. Contents are frozen while valid && !ready.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            load            - capture load_data/load_last this cycle
//            load_data/last  - beat to capture
//            out_ready       - downstream ready
//            out_data/valid/last - registered stream outputs
//            slot_free       - a load may be accepted this cycle
// Revision : 1.0  initial release
// ============================================================================
module axis_out_reg #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              slot_free
);

  // Accept when empty or when the held beat leaves this cycle; this gives
  // full throughput with a single storage slot.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_last  <= load_last;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_feeder
// Purpose  : Cuts a continuous complex-sample stream into FFT frames of
//            FRAME_LEN beats (tlast on the final beat), issues one config
//            beat before each frame, inserts an optional idle gap after each
//            frame, counts completed frames and latches FFT tlast errors.
// Ports    : aclk, aresetn             - clock, asynchronous active-low reset
//            enable                    - permits a new frame to start
//            s_axis_*                  - input sample stream (no tlast)
//            m_axis_data_*             - framed samples to the FFT core
//            m_axis_config_*           - per-frame config beat
//            fft_event_tlast_*         - FFT core error pulses
//            err_clr / err_sticky      - sticky error flag and its clear
//            frame_count               - completed frames, wraps at 2^16
//            busy                      - FSM not idle
// Revision : 1.0  initial release
// ============================================================================
module fft_frame_feeder #(
  parameter int         FRAME_LEN   = 8,
  parameter logic [7:0] CONFIG_WORD = 8'h00,
  parameter int         GAP_CYCLES  = 0,
  parameter int         DATA_W      = fft_pkg::DATA_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic              m_axis_data_tlast,
  output logic [7:0]        m_axis_config_tdata,
  output logic              m_axis_config_tvalid,
  input  logic              m_axis_config_tready,
  input  logic              fft_event_tlast_missing,
  input  logic              fft_event_tlast_unexpected,
  input  logic              err_clr,
  output logic              err_sticky,
  output logic [15:0]       frame_count,
  output logic              busy
);

  import fft_pkg::*;

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             cfg_valid;
  logic             slot_free;
  logic             in_fire;
  logic             out_fire;
  logic             last_in;
  logic             gap_done;

  assign s_axis_tready = (state == ST_DATA) && slot_free;
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign out_fire      = m_axis_data_tvalid && m_axis_data_tready;
  assign last_in       = (cnt == CNT_LAST);
  assign gap_done      = (gap_cnt == GAP_LAST);

  assign m_axis_config_tdata  = CONFIG_WORD;
  assign m_axis_config_tvalid = cfg_valid;
  assign busy                 = (state != ST_IDLE);

  axis_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (aclk),
    .rst_n     (aresetn),
    .load      (in_fire),
    .load_data (s_axis_tdata),
    .load_last (last_in),
    .out_ready (m_axis_data_tready),
    .out_data  (m_axis_data_tdata),
    .out_valid (m_axis_data_tvalid),
    .out_last  (m_axis_data_tlast),
    .slot_free (slot_free)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (enable) state_nx = ST_CFG;
      ST_CFG:   if (m_axis_config_tready) state_nx = ST_DATA;
      ST_DATA:  if (in_fire && last_in) state_nx = ST_DRAIN;
      // The tlast beat may already be leaving in the first DRAIN cycle.
      ST_DRAIN: if (out_fire && m_axis_data_tlast)
                  state_nx = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_done) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      cfg_valid   <= 1'b0;
      cnt         <= '0;
      gap_cnt     <= '0;
      frame_count <= '0;
      err_sticky  <= 1'b0;
    end else begin
      state <= state_nx;
      // Registered so config tvalid rises on CFG entry and holds until taken.
      cfg_valid <= (state_nx == ST_CFG);

      if (in_fire)
        cnt <= last_in ? '0 : cnt + 1'b1;

      if (state == ST_GAP)
        gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
      else
        gap_cnt <= '0;

      if (state == ST_DRAIN && out_fire && m_axis_data_tlast)
        frame_count <= frame_count + 16'd1;

      // Set has priority over clear.
      if (fft_event_tlast_missing || fft_event_tlast_unexpected)
        err_sticky <= 1'b1;
      else if (err_clr)
        err_sticky <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_feeder
// Purpose  : Self-checking bench for fft_frame_feeder. Instance A uses no
//            inter-frame gap, instance B a 100-cycle gap; sel picks which
//            one the stimulus and the stream model follow.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_frame_feeder;

  localparam int FL = 8;

  logic        aclk;
  logic        aresetn;
  logic        en_a, en_b, sel;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        dready, cready;
  logic        ev_miss, ev_unexp, err_clr;

  logic        a_tready, a_ov, a_ol, a_cv, a_err, a_busy;
  logic [63:0] a_od;
  logic [7:0]  a_cd;
  logic [15:0] a_fc;
  logic        b_tready, b_ov, b_ol, b_cv, b_err, b_busy;
  logic [63:0] b_od;
  logic [7:0]  b_cd;
  logic [15:0] b_fc;

  fft_frame_feeder #(.FRAME_LEN(FL), .CONFIG_WORD(8'h00), .GAP_CYCLES(0), .DATA_W(64)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .enable(en_a),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(a_tready),
    .m_axis_data_tdata(a_od), .m_axis_data_tvalid(a_ov), .m_axis_data_tready(dready),
    .m_axis_data_tlast(a_ol), .m_axis_config_tdata(a_cd), .m_axis_config_tvalid(a_cv),
    .m_axis_config_tready(cready), .fft_event_tlast_missing(ev_miss),
    .fft_event_tlast_unexpected(ev_unexp), .err_clr(err_clr), .err_sticky(a_err),
    .frame_count(a_fc), .busy(a_busy));

  fft_frame_feeder #(.FRAME_LEN(FL), .CONFIG_WORD(8'h00), .GAP_CYCLES(100), .DATA_W(64)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .enable(en_b),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_tready),
    .m_axis_data_tdata(b_od), .m_axis_data_tvalid(b_ov), .m_axis_data_tready(dready),
    .m_axis_data_tlast(b_ol), .m_axis_config_tdata(b_cd), .m_axis_config_tvalid(b_cv),
    .m_axis_config_tready(cready), .fft_event_tlast_missing(ev_miss),
    .fft_event_tlast_unexpected(ev_unexp), .err_clr(err_clr), .err_sticky(b_err),
    .frame_count(b_fc), .busy(b_busy));

  // Signals of the instance currently under test.
  wire        tready = sel ? b_tready : a_tready;
  wire        ov     = sel ? b_ov     : a_ov;
  wire        ol     = sel ? b_ol     : a_ol;
  wire [63:0] od     = sel ? b_od     : a_od;
  wire        cv     = sel ? b_cv     : a_cv;
  wire [7:0]  cd     = sel ? b_cd     : a_cd;
  wire        err    = sel ? b_err    : a_err;
  wire        busy   = sel ? b_busy   : a_busy;
  wire [15:0] fc     = sel ? b_fc     : a_fc;
  wire        en_act = sel ? en_b     : en_a;

  logic [63:0] samples [FL];
  int checks = 0;
  int errors = 0;
  int rmode  = 0;
  int ph     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Output ready pattern: always 1, or 1,0,0 repeating.
  initial begin
    dready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      if (rmode == 1) begin
        dready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        dready = 1'b1;
      end
    end
  end

  // ---------------- stream model and per-cycle compare ----------------
  logic [63:0] q[$];
  int          m_fc, m_oidx, m_iidx, cyc, cfg_count, lt_cyc, min_gap, gaps_seen;
  logic        m_may, m_err, lt_valid, en_low;
  logic        p_stall, p_in_hs, p_cfg_stall, p_cv;
  logic [63:0] p_od, p_in_d, first_out, last_tl_data;
  logic        p_ol, first_pending;

  initial begin
    cfg_count = 0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        chk("rst_outputs", {43'd0, ov, ol, tready, cv, err, busy, fc}, 64'd0);
        chk("rst_tdata", od, 64'd0);
        q.delete();
        m_fc = 0; m_oidx = 0; m_iidx = 0; m_may = 1'b0; m_err = 1'b0;
        lt_valid = 1'b0; en_low = 1'b0; min_gap = 1000000; gaps_seen = 0;
        p_stall = 1'b0; p_in_hs = 1'b0; p_cfg_stall = 1'b0; p_cv = 1'b0;
        first_pending = 1'b1;
      end else begin
        chk("frame_count", {48'd0, fc}, 64'(m_fc & 16'hffff));
        chk("err_sticky", {63'd0, err}, {63'd0, m_err});
        chk("s_tready", {63'd0, tready}, {63'd0, m_may && !(ov && !dready)});
        if (ov) chk("tlast", {63'd0, ol}, {63'd0, (m_oidx == FL - 1)});
        if (p_stall) chk("stall_stable", {ov, ol, od[61:0]}, {1'b1, p_ol, p_od[61:0]});
        if (p_stall) chk("stall_tdata", od, p_od);
        if (p_in_hs) chk("latency1", {ov, od[62:0]}, {1'b1, p_in_d[62:0]});
        if (p_cfg_stall) chk("cfg_hold", {63'd0, cv}, 64'd1);
        if (cv) chk("cfg_tdata", {56'd0, cd}, 64'h00);
        if (cv && !p_cv && lt_valid) begin
          automatic int idle = cyc - lt_cyc - 1;
          automatic int gexp = sel ? 100 : 0;
          gaps_seen++;
          if (idle < min_gap) min_gap = idle;
          chk("gap_min", {63'd0, (idle >= gexp)}, 64'd1);
          if (!en_low) chk("gap_len", 64'(idle), 64'(gexp + 1));
        end
        if (ov && dready) begin
          if (q.size() == 0) begin
            chk("out_unexpected", od, 64'hx);
          end else begin
            automatic logic [63:0] e = q.pop_front();
            chk("out_data", od, e);
          end
          if (first_pending) begin first_out = od; first_pending = 1'b0; end
          if (m_oidx == FL - 1) begin
            m_fc++; lt_cyc = cyc; lt_valid = 1'b1; en_low = 1'b0; last_tl_data = od;
          end
          m_oidx = (m_oidx + 1) % FL;
        end
        if (s_tvalid && tready) begin
          q.push_back(s_tdata);
          m_iidx++;
          if (m_iidx == FL) begin m_iidx = 0; m_may = 1'b0; end
        end
        if (cv && cready) begin m_may = 1'b1; cfg_count++; end
        if (!en_act) en_low = 1'b1;
        if (ev_miss || ev_unexp) m_err = 1'b1;
        else if (err_clr)        m_err = 1'b0;
        p_stall     = ov && !dready;
        p_od        = od;
        p_ol        = ol;
        p_in_hs     = s_tvalid && tready;
        p_in_d      = s_tdata;
        p_cfg_stall = cv && !cready;
        p_cv        = cv;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic stream(input int n, input int start);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 3000) begin
      s_tvalid = 1'b1;
      s_tdata  = samples[(start + i) % FL];
      @(negedge aclk);
      if (tready) i++;
      @(posedge aclk); #1;
      guard++;
    end
    s_tvalid = 1'b0;
    if (guard >= 3000) chk("stream_timeout", 64'(i), 64'(n));
  endtask

  task automatic wait_cfg();
    int k = 0;
    @(negedge aclk);
    while (!cv && k < 10) begin @(negedge aclk); k++; end
    chk("cfg_seen", {63'd0, cv}, 64'd1);
    @(posedge aclk); #1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge aclk);
    while (busy && k < budget) begin @(negedge aclk); k++; end
    chk("idle_reached", {63'd0, busy}, 64'd0);
    @(posedge aclk); #1;
  endtask

  initial begin
    samples[0] = 64'h000000003f800000;
    samples[1] = 64'hbf3504f33f3504f3;
    samples[2] = 64'hbf80000000000000;
    samples[3] = 64'hbf3504f3bf3504f3;
    samples[4] = 64'h00000000bf800000;
    samples[5] = 64'h3f3504f3bf3504f3;
    samples[6] = 64'h3f80000000000000;
    samples[7] = 64'hbf7cd925be20305b;
    aresetn = 1'b0; sel = 1'b0; en_a = 1'b0; en_b = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; cready = 1'b1;
    ev_miss = 1'b0; ev_unexp = 1'b0; err_clr = 1'b0;
    cycles(3);
    aresetn = 1'b1;
    cycles(2);

    // 1: one plain frame
    en_a = 1'b1;
    stream(8, 0);
    en_a = 1'b0;
    wait_idle(20);
    @(negedge aclk); #1;
    chk("t1_frame_count", {48'd0, fc}, 64'd1);
    chk("t1_cfg_beats", 64'(cfg_count), 64'd1);
    chk("t1_first_out", first_out, 64'h000000003f800000);
    chk("t1_last_out", last_tl_data, 64'hbf7cd925be20305b);
    @(posedge aclk); #1;

    // 2: output back-pressure 1,0,0 pattern
    rmode = 1;
    en_a = 1'b1;
    stream(8, 0);
    en_a = 1'b0;
    wait_idle(60);
    rmode = 0;
    @(negedge aclk); #1;
    chk("t2_frame_count", {48'd0, fc}, 64'd2);
    @(posedge aclk); #1;

    // 3: config channel stalled for 20 cycles
    cready = 1'b0;
    en_a = 1'b1;
    wait_cfg();
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      chk("t3_cfg_stall", {62'd0, cv, tready}, 64'b10);
    end
    @(posedge aclk); #1;
    cready = 1'b1;
    stream(8, 0);
    en_a = 1'b0;
    wait_idle(20);
    @(negedge aclk); #1;
    chk("t3_frame_count", {48'd0, fc}, 64'd3);
    @(posedge aclk); #1;

    // 5: enable dropped after beat 3
    en_a = 1'b1;
    stream(3, 0);
    en_a = 1'b0;
    stream(5, 3);
    wait_idle(20);
    cycles(20);
    @(negedge aclk); #1;
    chk("t5_idle_busy", {63'd0, busy}, 64'd0);
    chk("t5_frame_count", {48'd0, fc}, 64'd4);
    chk("t5_cfg_beats", 64'(cfg_count), 64'd4);
    @(posedge aclk); #1;

    // 6: reset mid-frame, then sticky error behaviour
    en_a = 1'b1;
    stream(5, 0);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("t6_rst_now", {44'd0, ov, ol, tready, cv, busy, fc[14:0]}, 64'd0);
    cycles(2);
    aresetn = 1'b1;
    wait_cfg();
    @(negedge aclk);
    chk("t6_busy", {63'd0, busy}, 64'd1);
    chk("t6_fc_zero", {48'd0, fc}, 64'd0);
    @(posedge aclk); #1;
    stream(8, 0);
    en_a = 1'b0;
    wait_idle(20);
    @(negedge aclk);
    chk("t6_frame_count", {48'd0, fc}, 64'd1);
    @(posedge aclk); #1;
    ev_miss = 1'b1; err_clr = 1'b1;
    @(posedge aclk); #1;
    ev_miss = 1'b0; err_clr = 1'b0;
    @(negedge aclk);
    chk("t6_err_set_wins", {63'd0, err}, 64'd1);
    @(posedge aclk); #1;
    err_clr = 1'b1;
    @(posedge aclk); #1;
    err_clr = 1'b0;
    @(negedge aclk);
    chk("t6_err_cleared", {63'd0, err}, 64'd0);
    @(posedge aclk); #1;
    ev_unexp = 1'b1;
    @(posedge aclk); #1;
    ev_unexp = 1'b0;
    @(negedge aclk);
    chk("t6_err_unexp", {63'd0, err}, 64'd1);
    @(posedge aclk); #1;

    // 4: 100-cycle gap instance, three back-to-back frames
    aresetn = 1'b0;
    sel = 1'b1;
    cycles(2);
    aresetn = 1'b1;
    cycles(1);
    en_b = 1'b1;
    stream(24, 0);
    en_b = 1'b0;
    wait_idle(400);
    @(negedge aclk); #1;
    chk("t4_frame_count", {48'd0, fc}, 64'd3);
    chk("t4_gaps_seen", 64'(gaps_seen), 64'd2);
    chk("t4_min_gap", {63'd0, (min_gap >= 100)}, 64'd1);
    chk("t4_cfg_beats", 64'(cfg_count), 64'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
